// File: rtl/dram_bist_pkg.sv
// Shared types and constants for the distributed-RAM board test.
// Holds the BIST state encoding, pattern seed, switch/LED bit positions and the fault-inject address.
package dram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_RD_A,
        ST_WR_B,
        ST_RD_B,
        ST_PASS,
        ST_FAIL
    } bist_state_t;

    localparam logic [7:0] PAT_A = 8'h55;

    localparam int unsigned LED_BUSY = 8;
    localparam int unsigned LED_PASS = 9;
    localparam int unsigned LED_FAIL = 10;

    localparam int unsigned SW_DATA_LSB = 5;
    localparam int unsigned SW_INJECT   = 5;
    localparam int unsigned SW_START    = 13;
    localparam int unsigned SW_MODE     = 14;
    localparam int unsigned SW_WE       = 15;

    localparam int unsigned INJECT_ADDR = 3;

    // Pattern A for a word address; pattern B is its complement.
    function automatic logic [7:0] pattern_a(input logic [7:0] addr);
        return addr ^ PAT_A;
    endfunction

endpackage

// File: rtl/dram_sp_nx.sv
// Single-port LUT RAM: synchronous write, asynchronous read, configuration-time init.
// Plain inferable form so synthesis packs it into RAM32X1S..RAM256X1S primitives.
module dram_sp_nx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 5,
    parameter logic [7:0]  INIT_VAL  = 8'h02
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL[WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dram_bist_nx.sv
// Board test top: switch synchroniser, manual RAM access, march-style BIST FSM and LED status.
// UART is looped straight through.
module dram_bist_nx
    import dram_bist_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 5,
    parameter logic [7:0]  INIT_VAL  = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    logic [15:0]          sw_meta;
    logic [15:0]          sws;
    logic                 start_prev;
    logic                 start_edge;
    bist_state_t          state, state_n;
    logic [ADDR_BITS-1:0] cnt, cnt_n;
    logic [ADDR_BITS-1:0] fail_addr, fail_addr_n;
    logic [15:0]          led_n;
    logic [7:0]           pat8;
    logic [WIDTH-1:0]     expect_data;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [WIDTH-1:0]     mem_wdata;
    logic [WIDTH-1:0]     mem_rdata;
    logic                 mismatch;
    logic                 last_addr;

    assign tx = rx;

    // Two-flop synchroniser plus start-edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta    <= '0;
            sws        <= '0;
            start_prev <= 1'b0;
        end else begin
            sw_meta    <= sw;
            sws        <= sw_meta;
            start_prev <= sws[SW_START];
        end
    end

    assign start_edge = sws[SW_START] & ~start_prev;
    assign last_addr  = (cnt == '1);

    // RAM port mux: switches in manual mode, BIST address/pattern otherwise.
    always_comb begin
        pat8        = pattern_a(8'(cnt));
        expect_data = (state == ST_RD_B) ? ~pat8[WIDTH-1:0] : pat8[WIDTH-1:0];
        mem_we      = 1'b0;
        mem_addr    = cnt;
        mem_wdata   = pat8[WIDTH-1:0];
        if (!sws[SW_MODE]) begin
            mem_we    = sws[SW_WE];
            mem_addr  = ADDR_BITS'(sws[4:0]);
            mem_wdata = sws[SW_DATA_LSB +: WIDTH];
        end else if (state == ST_WR_A) begin
            mem_we = 1'b1;
        end else if (state == ST_WR_B) begin
            mem_we    = 1'b1;
            mem_wdata = ~pat8[WIDTH-1:0];
            if (sws[SW_INJECT] && (cnt == ADDR_BITS'(INJECT_ADDR))) begin
                mem_wdata[0] = ~mem_wdata[0];
            end
        end
    end

    assign mismatch = (mem_rdata != expect_data);

    dram_sp_nx #(
        .WIDTH    (WIDTH),
        .ADDR_BITS(ADDR_BITS),
        .INIT_VAL (INIT_VAL)
    ) u_ram (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            fail_addr <= '0;
            led       <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            fail_addr <= fail_addr_n;
            led       <= led_n;
        end
    end

    // Next state; LEDs are derived from the next state so status lands on the same edge.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        fail_addr_n = fail_addr;
        led_n       = '0;

        if (!sws[SW_MODE]) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start_edge) begin
                        state_n = ST_WR_A;
                        cnt_n   = '0;
                    end
                end
                ST_WR_A, ST_WR_B: begin
                    cnt_n = cnt + 1'b1;
                    if (last_addr) begin
                        state_n = (state == ST_WR_A) ? ST_RD_A : ST_RD_B;
                    end
                end
                ST_RD_A, ST_RD_B: begin
                    if (mismatch) begin
                        state_n     = ST_FAIL;
                        fail_addr_n = cnt;
                        cnt_n       = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (last_addr) begin
                            state_n = (state == ST_RD_A) ? ST_WR_B : ST_PASS;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        if (!sws[SW_MODE]) begin
            led_n[7:0] = 8'(mem_rdata);
        end else if (state_n == ST_FAIL) begin
            led_n[7:0] = 8'(fail_addr_n);
        end
        led_n[LED_BUSY] = (state_n == ST_WR_A) || (state_n == ST_RD_A) ||
                          (state_n == ST_WR_B) || (state_n == ST_RD_B);
        led_n[LED_PASS] = (state_n == ST_PASS);
        led_n[LED_FAIL] = (state_n == ST_FAIL);
    end

endmodule

// File: doc/dram_bist_nx.md
# dram_bist_nx

Parametrised distributed-RAM board test top. One inferred single-port LUT RAM, WIDTH bits × 2^ADDR_BITS words, is driven two ways: manually from switches, or by a built-in march-style self-test FSM. Pass/fail status appears on LEDs. The UART is passed through (`tx = rx`). This block is the scalable successor to the fixed 8 × 32x1 RAM test and is used to validate LUT-RAM packing across widths and depths.

## Interface
- `WIDTH`, default 8: data bits per word. Legal range 1..8.
- `ADDR_BITS`, default 5: RAM depth is 2^ADDR_BITS. Legal range 5..8.
- `INIT_VAL`, default 8'h02: configuration-time value of every word, low WIDTH bits used. Reset does not affect it.
- `clk` in, 1: the only clock.
- `rst` in, 1: asynchronous, active-high reset.
- `rx` in, 1: UART receive.
- `tx` out, 1: equals `rx`, purely combinational.
- `sw` in, 16: mode and data switches, asynchronous to `clk`.
  - `[4:0]` manual address, zero-extended to ADDR_BITS.
  - `[12:5]` manual write data, low WIDTH bits used.
  - `[13]` BIST start.
  - `[14]` mode: 0 = manual, 1 = BIST.
  - `[15]` manual write enable.
  - In BIST mode, `[5]` is fault inject.
- `led` out, 16: status outputs.
  - `[7:0]` in manual mode: readback data, zero-extended. In BIST mode: failing address, low 8 bits.
  - `[8]` busy, `[9]` pass, `[10]` fail.
  - `[15:11]` constant 0.

## Operation
- All of `sw` passes through a 2-flop synchroniser. All logic uses the synchronised copy `sws`.
- Manual mode, `sws[14]=0`:
  - While `sws[15]=1`, write `sws[12:5]` to address `sws[4:0]` on every clock (level-sensitive).
  - Read is asynchronous. `led[7:0]` registers `mem[addr]` every cycle.
  - The BIST FSM is forced to IDLE and `led[10:8]` reads 0.
- BIST FSM states: IDLE, WR_A, RD_A, WR_B, RD_B, PASS, FAIL.
  - IDLE → WR_A on a rising edge of `sws[13]` while `sws[14]=1`.
  - Each WR/RD state walks address 0..2^ADDR_BITS−1 at one address per cycle, then moves to the next state.
  - Pattern A is `(addr ^ 8'h55)[WIDTH-1:0]`. Pattern B is `~A`.
  - RD states compare read data with expected data in the same cycle.
  - On the first mismatch: capture the address, go to FAIL, and skip the remaining reads.
  - RD_B complete with no mismatch → PASS.
- Fault inject: if `sws[5]=1` during WR_B, bit 0 of the word written at address 3 is inverted. Expected result is FAIL with address 3.
- PASS and FAIL hold until the next start edge (which restarts at WR_A) or until `sws[14]` drops (→ IDLE).
- `sws[14]` dropping mid-test aborts to IDLE immediately. Status clears and RAM contents are left partially written.
- Manual writes are gated off whenever `sws[14]=1`.
- Status LEDs:
  - busy = any WR or RD state.
  - pass = PASS.
  - fail = FAIL.
  - Fail address LEDs are 0 unless in FAIL.

## Timing
- Reset values: state IDLE, all `led` bits 0, synchronisers 0, address counter 0. RAM is not reset.
- Switch to internal effect: 2 cycles. Start edge is detected on the third cycle after `sw[13]` rises.
- Manual readback: `led[7:0]` updates 1 cycle after `sws` changes, i.e. 3 cycles after `sw` changes.
- Write then read at the same address: new data is visible on `led` 1 cycle after the write edge.
- BIST pass run: exactly 4·2^ADDR_BITS cycles in busy states, then PASS. That is 128 cycles at the default depth.
- FAIL is registered on the cycle after the mismatching address is presented. Busy falls on the same edge.
- Address counter wrap-around from max to 0 coincides with the state advance. There is no extra idle cycle between phases.
- Reset asserted mid-test: immediate return to IDLE with LEDs at 0.

## Structure
- Package `dram_bist_pkg`:
  - the state enum;
  - pattern constant 8'h55;
  - LED bit index constants;
  - `INJECT_ADDR = 3`.
- Sub-module `dram_sp_nx`: parametrised WIDTH × 2^ADDR_BITS, synchronous write, asynchronous read, INIT_VAL init. Written so synthesis maps it to RAM32X1S/RAM64X1S/RAM128X1S/RAM256X1S.
- The top holds the synchroniser, edge detect, FSM, comparator and LED mux.

## Test plan
- Reset with manual mode, address 0 → `led` = 16'h0002 after 3 cycles (INIT_VAL readback). `tx` follows `rx` with no delay.
- Manual: sw = addr 5, data 8'hA7, WE → release WE, read addr 5 → `led[7:0]` = 8'hA7. Addr 4 still reads 8'h02.
- BIST with default parameters: mode=1, pulse start → busy for exactly 128 cycles, then `led[9]` = 1, `led[10]` = 0.
- BIST with inject=1 → `led[10]` = 1, `led[7:0]` = 8'h03. Busy duration is 3·32+4 cycles.
- Drop mode during RD_A → next cycle after sync: `led[10:8]` = 0 and state is IDLE. Re-enter mode and start → clean PASS.
- Sweep WIDTH ∈ {1, 4, 8}, ADDR_BITS ∈ {5, 6, 8} → PASS after 4·2^ADDR_BITS cycles in each configuration. Assert `rst` mid-WR_B → all LEDs 0 within the same cycle.
